// File: rtl/ls_result_queue_pkg.sv
// Shared types and default widths for the load/store result queue.
package ls_result_queue_pkg;

    localparam int XLEN      = 32;
    localparam int ARN_WIDTH = 5;
    localparam int RRN_WIDTH = 6;

    typedef struct packed {
        logic [XLEN-1:0]      result;
        logic [ARN_WIDTH-1:0] arn;
        logic [RRN_WIDTH-1:0] rrn;
        logic                 fault;
    } ls_result_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ls_result_queue_result_fifo_core.sv
// Generic DEPTH-entry ring buffer of ls_result_t with head/tail pointers and a separate count.
module result_fifo_core
    import ls_result_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  ls_result_t       wdata_i,
    output ls_result_t       rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    ls_result_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // Full/empty gating here keeps the count within [0, DEPTH] whatever the caller asks for.
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/ls_result_queue.sv
// Load/store result queue feeding the CDB arbiter: request while non-empty, drive CDB on grant.
// Optional zero-latency empty-queue bypass enabled by defining LS_RESULT_BYPASS_EN.
module ls_result_queue #(
    parameter int DEPTH     = 4,
    parameter int XLEN      = ls_result_queue_pkg::XLEN,
    parameter int ARN_WIDTH = ls_result_queue_pkg::ARN_WIDTH,
    parameter int RRN_WIDTH = ls_result_queue_pkg::RRN_WIDTH
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_valid,
    input  logic [XLEN-1:0]            i_result,
    input  logic [ARN_WIDTH-1:0]       i_arn,
    input  logic [RRN_WIDTH-1:0]       i_rrn,
    input  logic                       i_fault,
    output logic                       o_ready,
    output logic                       o_get_bus,
    input  logic                       i_bus_granted,
    output logic                       o_cdb_valid,
    output logic [XLEN-1:0]            o_cdb_result,
    output logic [ARN_WIDTH-1:0]       o_cdb_arn,
    output logic [RRN_WIDTH-1:0]       o_cdb_rrn,
    output logic                       o_cdb_fault,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    import ls_result_queue_pkg::*;

    ls_result_t wr_entry, head_entry, cdb_entry;
    logic       bypass;
    logic       push;

    assign wr_entry = '{result: i_result, arn: i_arn, rrn: i_rrn, fault: i_fault};

    result_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clock),
        .rst_ni  (i_reset_n),
        .clear_i (i_clear),
        .push_i  (push),
        .pop_i   (i_bus_granted),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .full_o  (o_full),
        .empty_o (o_empty),
        .count_o (o_count)
    );

    // o_ready looks only at registered count, so a grant can never open a slot in the same cycle.
    assign o_ready = !o_full;

`ifdef LS_RESULT_BYPASS_EN
    assign bypass    = o_empty && i_valid && i_bus_granted && !i_clear;
    assign o_get_bus = !o_empty || i_valid;
`else
    assign bypass    = 1'b0;
    assign o_get_bus = !o_empty;
`endif

    assign push = i_valid && !bypass;

    // Head stays valid until the edge, so a grant during a clear still drives the CDB.
    always_comb begin
        o_cdb_valid = 1'b0;
        cdb_entry   = '0;
        if (i_bus_granted && !o_empty) begin
            o_cdb_valid = 1'b1;
            cdb_entry   = head_entry;
        end else if (bypass) begin
            o_cdb_valid = 1'b1;
            cdb_entry   = wr_entry;
        end
    end

    assign o_cdb_result = cdb_entry.result;
    assign o_cdb_arn    = cdb_entry.arn;
    assign o_cdb_rrn    = cdb_entry.rrn;
    assign o_cdb_fault  = cdb_entry.fault;

`ifndef SYNTHESIS
    a_enq_while_full: assert property (@(posedge i_clock) disable iff (!i_reset_n)
        !(i_valid && o_full && !i_clear))
        else $warning("ls_result_queue: protocol warning, i_valid while full, input dropped");

    a_cdb_implies_req: assert property (@(posedge i_clock) disable iff (!i_reset_n)
        o_cdb_valid |-> o_get_bus);
`endif

endmodule

// File: tb/tb_ls_result_queue.sv
// Randomized self-checking bench for ls_result_queue against a queue-based reference model.
module tb_ls_result_queue;

    localparam int DEPTH = 4;
`ifdef LS_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  a;
        logic [5:0]  n;
        logic        f;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_result = '0;
    logic [4:0]  i_arn = '0;
    logic [5:0]  i_rrn = '0;
    logic        i_fault = 1'b0;
    logic        i_bus_granted = 1'b0;
    logic        o_ready, o_get_bus, o_cdb_valid, o_cdb_fault, o_full, o_empty;
    logic [31:0] o_cdb_result;
    logic [4:0]  o_cdb_arn;
    logic [5:0]  o_cdb_rrn;
    logic [2:0]  o_count;
    logic [51:0] obs;

    int total = 0;
    int bad = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    ls_result_queue #(.DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .i_result(i_result), .i_arn(i_arn), .i_rrn(i_rrn), .i_fault(i_fault),
        .o_ready(o_ready), .o_get_bus(o_get_bus), .i_bus_granted(i_bus_granted),
        .o_cdb_valid(o_cdb_valid), .o_cdb_result(o_cdb_result), .o_cdb_arn(o_cdb_arn),
        .o_cdb_rrn(o_cdb_rrn), .o_cdb_fault(o_cdb_fault), .o_full(o_full),
        .o_empty(o_empty), .o_count(o_count)
    );

    assign obs = {o_count, o_empty, o_full, o_ready, o_get_bus, o_cdb_valid,
                  o_cdb_result, o_cdb_arn, o_cdb_rrn, o_cdb_fault};

    // Expected outputs for the current inputs and queued contents.
    function automatic logic [51:0] exp_vec();
        int   n   = q.size();
        logic e   = (n == 0);
        logic f   = (n == DEPTH);
        logic byp = BYP && e && i_valid && i_bus_granted && !i_clear;
        logic gb  = !e || (BYP && i_valid);
        logic cv  = 1'b0;
        ent_t h   = '0;
        if (i_bus_granted && !e) begin
            cv = 1'b1;
            h  = q[0];
        end else if (byp) begin
            cv = 1'b1;
            h  = '{r: i_result, a: i_arn, n: i_rrn, f: i_fault};
        end
        return {3'(n), e, f, !f, gb, cv, h.r, h.a, h.n, h.f};
    endfunction

    function automatic void model_edge();
        int   n   = q.size();
        logic byp = BYP && (n == 0) && i_valid && i_bus_granted && !i_clear;
        if (i_clear) begin
            q.delete();
        end else begin
            if (i_bus_granted && n > 0) void'(q.pop_front());
            if (i_valid && n < DEPTH && !byp)
                q.push_back('{r: i_result, a: i_arn, n: i_rrn, f: i_fault});
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] a,
                         input logic [5:0] n, input logic f, input logic g, input logic c);
        @(negedge clk);
        i_valid = v; i_result = r; i_arn = a; i_rrn = n; i_fault = f;
        i_bus_granted = g; i_clear = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic test_reset();
        logic [51:0] rst_exp;
        rst_exp = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 44'd0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if (obs !== rst_exp) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", obs, rst_exp);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 5'(i), 6'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o_count !== 3'd3) begin
            bad++; $display("FAIL pre_reset_count got=%0d exp=3", o_count);
        end
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        total++;
        if ({o_count, o_empty, o_get_bus} !== {3'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL async_reset got cnt=%0d empty=%b req=%b exp cnt=0 empty=1 req=0",
                            o_count, o_empty, o_get_bus);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_in_order();
        logic [31:0] seen[$];
        logic [31:0] want[3] = '{32'hA1, 32'hA2, 32'hA3};
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1'b1, want[i], 5'(i + 4), 6'(i + 1), 1'b0, 1'b1, 1'b0);
            else       drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL in_order cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (o_cdb_valid) seen.push_back(o_cdb_result);
            tick();
        end
        total++;
        if (seen.size() != 3) begin
            bad++; $display("FAIL in_order_count got=%0d exp=3", seen.size());
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (((k < seen.size()) ? seen[k] : 32'hx) !== want[k]) begin
                bad++; $display("FAIL in_order_seq idx=%0d got=%h exp=%h", k,
                                (k < seen.size()) ? seen[k] : 32'hx, want[k]);
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o_get_bus !== 1'b0) begin
            bad++; $display("FAIL in_order_idle_req got=%b exp=0", o_get_bus);
        end
    endtask

    task automatic test_full();
        logic [31:0] pushed[$];
        logic [31:0] seen[$];
        for (int i = 0; i < DEPTH; i++) begin
            pushed.push_back($urandom & 32'h7FFF_FFFF);
            drive(1'b1, pushed[i], 5'(i), 6'(i + 8), 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hFF, 5'd1, 6'd1, 1'b1, 1'b0, 1'b0);
            total++;
            if ({o_full, o_ready, o_count} !== {1'b1, 1'b0, 3'd4}) begin
                bad++; $display("FAIL full_block got full=%b rdy=%b cnt=%0d exp 1 0 4",
                                o_full, o_ready, o_count);
            end
            tick();
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            if (o_cdb_valid) seen.push_back(o_cdb_result);
            tick();
        end
        total++;
        if (seen != pushed) begin
            bad++; $display("FAIL full_no_ff got_n=%0d exp_n=%0d (0xFF must not appear)",
                            seen.size(), pushed.size());
        end
    endtask

    task automatic test_full_grant();
        logic [31:0] last;
        int n_out = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h100 + i, 5'(i), 6'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hB0, 5'd3, 6'd33, 1'b0, 1'b1, 1'b0);
        total++;
        if ({o_cdb_valid, o_cdb_result, o_ready} !== {1'b1, 32'h100, 1'b0}) begin
            bad++; $display("FAIL full_grant_pop got v=%b r=%h rdy=%b exp 1 100 0",
                            o_cdb_valid, o_cdb_result, o_ready);
        end
        tick();
        drive(1'b1, 32'hB0, 5'd3, 6'd33, 1'b0, 1'b0, 1'b0);
        total++;
        if ({o_count, o_ready} !== {3'd3, 1'b1}) begin
            bad++; $display("FAIL full_grant_after got cnt=%0d rdy=%b exp 3 1", o_count, o_ready);
        end
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o_count !== 3'd4) begin
            bad++; $display("FAIL full_grant_accept got=%0d exp=4", o_count);
        end
        last = '0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (o_cdb_valid) begin last = o_cdb_result; n_out++; end
            tick();
        end
        total++;
        if ({n_out[3:0], last} !== {4'd4, 32'hB0}) begin
            bad++; $display("FAIL full_grant_tail got n=%0d last=%h exp 4 b0", n_out, last);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            drive(i < 10, $urandom, 5'($urandom), 6'($urandom), 1'($urandom), 1'(i % 2), 1'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            total++;
            if (o_count > 3'd4) begin
                bad++; $display("FAIL wrap_bound cyc=%0d got=%0d exp<=4", i, o_count);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 32'hC1, 5'd1, 6'd1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hC2, 5'd2, 6'd2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h77, 5'd7, 6'd7, 1'b0, 1'b1, 1'b1);
        total++;
        if ({o_cdb_valid, o_cdb_result} !== {1'b1, 32'hC1}) begin
            bad++; $display("FAIL clear_head got v=%b r=%h exp 1 c1", o_cdb_valid, o_cdb_result);
        end
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        total++;
        if ({o_count, o_get_bus, o_cdb_valid} !== {3'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL clear_after got cnt=%0d req=%b v=%b exp 0 0 0",
                            o_count, o_get_bus, o_cdb_valid);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [32:0] exp_now;
        logic [2:0]  exp_cnt;
`ifdef LS_RESULT_BYPASS_EN
        exp_now = {1'b1, 32'h5};
        exp_cnt = 3'd0;
`else
        exp_now = {1'b0, 32'h0};
        exp_cnt = 3'd1;
`endif
        drive(1'b1, 32'h5, 5'd5, 6'd5, 1'b0, 1'b1, 1'b0);
        total++;
        if ({o_cdb_valid, o_cdb_result} !== exp_now) begin
            bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", {o_cdb_valid, o_cdb_result}, exp_now);
        end
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o_count !== exp_cnt) begin
            bad++; $display("FAIL bypass_count got=%0d exp=%0d", o_count, exp_cnt);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0); tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom, 5'($urandom), 6'($urandom), 1'($urandom),
                  1'($urandom), ($urandom % 32) == 0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_full_grant();
        test_wrap();
        test_clear();
        test_bypass();
        test_random();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ls_result_queue.md
Name: ls_result_queue

Overview:
- Buffers completed load/store results between the load/store unit and the CDB arbiter in the load/store combo.
- The load/store unit pushes one result per cycle. The queue raises a bus request while it holds data, and drives the CDB for one cycle per arbiter grant.
- Decouples load/store unit progress from CDB contention. Backpressure to the reservation station is via o_full/o_ready.

Parameters:
- DEPTH, 4, number of result entries; power of two, ≥2.
- XLEN, 32, result data width.
- ARN_WIDTH, 5, architectural register number width.
- RRN_WIDTH, 6, rename register number width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush (mispredict); drops all entries.
- i_valid  in  1  load/store unit presents a result this cycle.
- i_result  in  XLEN  result data (load value; 0 for stores).
- i_arn  in  ARN_WIDTH  destination architectural register.
- i_rrn  in  RRN_WIDTH  destination rename register.
- i_fault  in  1  misaligned or faulting access flag.
- o_ready  out  1  queue can accept this cycle (= !o_full).
- o_get_bus  out  1  request to CDB arbiter.
- i_bus_granted  in  1  arbiter grant for the current cycle.
- o_cdb_valid  out  1  CDB payload valid.
- o_cdb_result  out  XLEN  CDB data.
- o_cdb_arn  out  ARN_WIDTH  CDB architectural register number.
- o_cdb_rrn  out  RRN_WIDTH  CDB rename register number.
- o_cdb_fault  out  1  CDB fault flag.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - Pointers and count go to 0; o_empty=1; o_full=0; o_ready=1.
  - o_get_bus, o_cdb_valid and all o_cdb_* fields are 0.
  - Entry storage is not reset.
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits. Pointers wrap from DEPTH-1 to 0. Full/empty come from a separate count register.
- Enqueue: on a rising edge with i_valid && o_ready, write {result, arn, rrn, fault} at tail; tail+1.
  - i_valid while o_full: input ignored, no entry written. The load/store unit holds i_valid itself.
- Request: o_get_bus = !o_empty, combinational from registered state.
- Dequeue:
  - o_cdb_valid = i_bus_granted && !o_empty.
  - o_cdb_* show the head entry when o_cdb_valid=1, else 0.
  - At the next edge, head+1.
  - A grant while empty has no effect.
- Latency: an enqueued result can appear on the CDB no earlier than the cycle after its write.
- Simultaneous enqueue and dequeue: count unchanged and both pointers advance. When full, enqueue is blocked because o_ready depends only on registered count, so there is no grant→ready combinational path.
- i_clear takes priority over everything:
  - At the edge: pointers and count go to 0; a same-cycle enqueue is discarded.
  - A same-cycle grant still drives the CDB that cycle (the head is valid until the edge).
- Count arithmetic: count_next = count + enq - deq. Never exceeds DEPTH and never goes below 0.
- Assertions:
  - Enqueue while full is reported as a protocol warning.
  - o_cdb_valid implies o_get_bus.

Optional Feature:
- Macro LS_RESULT_BYPASS_EN.
- When defined:
  - o_get_bus = !o_empty || i_valid.
  - If o_empty && i_valid && i_bus_granted && !i_clear, the input drives o_cdb_* directly with o_cdb_valid=1 and is not enqueued (zero-cycle latency).
- When undefined: behaviour exactly as above (minimum one cycle of latency).

Decomposition:
- pkg_defines gains:
  - typedef ls_result_t, a packed struct {result, arn, rrn, fault}.
  - Constants XLEN, ARN_WIDTH, RRN_WIDTH.
- One natural sub-module: result_fifo_core, a generic DEPTH x ls_result_t ring buffer (pointers, count, full/empty). ls_result_queue adds the request/grant/CDB-drive logic and the bypass.

Test Plan:
- Reset mid-operation: 3 entries queued, assert i_reset_n=0 → o_count=0, o_empty=1, o_get_bus=0 asynchronously.
- Push 0xA1,0xA2,0xA3 (rrn 1,2,3), grant every cycle → CDB shows A1, A2, A3 in order, each with o_cdb_valid=1, then o_get_bus=0.
- Fill to DEPTH=4 with no grant, then present i_valid with 0xFF → o_full=1, o_ready=0, o_count stays 4, 0xFF is never seen on the CDB.
- Full queue, grant while i_valid high → one entry popped, o_count 3, o_ready=1 next cycle, new entry accepted then.
- Wrap-around: 10 push/pop pairs with grant alternating on/off → FIFO order preserved across pointer wrap and o_count never exceeds 4.
- i_clear with 2 entries plus a same-cycle i_valid and grant → head driven that cycle, o_count=0 next cycle, the pushed value is discarded. With LS_RESULT_BYPASS_EN, an empty queue receiving i_valid=0x5 with grant → o_cdb_result=0x5 the same cycle and o_count stays 0.
